inst_fetch_unit: RTL and testbench

INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

---
 rtl/inst_fetch_unit_if.sv | 30 +++
 rtl/inst_fetch_unit.sv | 144 ++++++++++++++
 tb/tb_inst_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit_if
// Instruction-memory request/acknowledge bus between the fetch unit and the
// instruction memory.
//   imem_req   : fetch request, driven by the fetch unit
//   imem_addr  : fetch address (the fetch unit's current PC)
//   imem_ack   : memory returns imem_rdata in this cycle
//   imem_rdata : fetched instruction word
// Modports: master = fetch unit side, slave = memory side.
// -----------------------------------------------------------------------------
interface inst_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
// Multi-cycle instruction fetch unit. It requests the word at PC, holds it in
// Inst while the downstream stage executes it, then computes the next PC
// (sequential, branch or jump) and starts the next fetch.
//
// Ports
//   clk        : single clock, all state updates on the rising edge
//   rst        : synchronous active-high reset
//   imem       : instruction-memory bus (master side: req/addr out, ack/rdata in)
//   Inst       : held instruction register
//   inst_valid : Inst is valid and executing
//   PC         : address of Inst
//   ex_done    : downstream stage finished Inst; Jump/Branch/Zero valid now
//   Jump       : jump decode from the control unit
//   Branch     : branch decode from the control unit
//   Zero       : ALU zero flag
//   retired    : count of completed instructions (wraps modulo 2^32)
// -----------------------------------------------------------------------------
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                      clk,
  input  logic                      rst,
  inst_fetch_unit_if.master         imem,
  output logic [31:0]               Inst,
  output logic                      inst_valid,
  output logic [31:0]               PC,
  input  logic                      ex_done,
  input  logic                      Jump,
  input  logic                      Branch,
  input  logic                      Zero,
  output logic [31:0]               retired
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        fetch_accept;   // ack seen while requesting
  logic        exec_accept;    // ex_done seen while issuing

  logic [31:0] pc4;
  logic [31:0] jump_target;
  logic [31:0] branch_offset;
  logic [31:0] branch_target;
  logic [31:0] next_pc;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic. The accept strobes are only raised in the state that
  // is allowed to consume the event, so a stray ack outside REQ or a stray
  // ex_done outside ISSUE has no effect.
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first, otherwise a path
  // through the case that skips an assignment would infer a latch.
  always_comb begin
    state_d      = state_q;
    fetch_accept = 1'b0;
    exec_accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        if (imem.imem_ack) begin
          fetch_accept = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (ex_done) begin
          exec_accept = 1'b1;
          state_d     = REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request and valid are pure state decodes, so they drop in the same cycle
  // the state changes and never glitch against the registered PC/Inst.
  assign imem.imem_req  = (state_q == REQ);
  assign imem.imem_addr = PC;
  assign inst_valid     = (state_q == ISSUE);

  // ---------------------------------------------------------------------------
  // Next-PC computation, all 32-bit modulo arithmetic.
  // Jump beats branch; a branch is only taken when Zero is set.
  // ---------------------------------------------------------------------------
  always_comb begin
    pc4           = PC + 32'd4;
    jump_target   = {pc4[31:28], Inst[25:0], 2'b00};
    branch_offset = {{14{Inst[15]}}, Inst[15:0], 2'b00};
    branch_target = pc4 + branch_offset;
    if (Jump) begin
      next_pc = jump_target;
    end else if (Branch && Zero) begin
      next_pc = branch_target;
    end else begin
      next_pc = pc4;
    end
  end

  // ---------------------------------------------------------------------------
  // Instruction register, PC and retire counter. Reset has priority over any
  // simultaneous ack or ex_done. The low PC bits are forced to zero at reset;
  // every computed target is word aligned, so they stay zero afterwards.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      PC      <= {RESET_PC[31:2], 2'b00};
      Inst    <= 32'd0;
      retired <= 32'd0;
    end else begin
      if (fetch_accept) begin
        Inst <= imem.imem_rdata;
      end
      if (exec_accept) begin
        PC      <= next_pc;
        retired <= retired + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_unit
// Self-checking bench for inst_fetch_unit. A chained table of instructions is
// fetched and executed; expected fetch addresses go into a scoreboard queue
// when ex_done is driven and are compared when the next request appears.
// Hand-written sequences cover the handshake, reset and wrap corner cases.
// -----------------------------------------------------------------------------
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst_w;
  logic        ex_done;
  logic        Jump;
  logic        Branch;
  logic        Zero;

  logic [31:0] Inst;
  logic        inst_valid;
  logic [31:0] PC;
  logic [31:0] retired;

  logic [31:0] inst_w;
  logic        inst_valid_w;
  logic [31:0] pc_w;
  logic [31:0] retired_w;

  inst_fetch_unit_if imem_bus ();
  inst_fetch_unit_if imem_bus_w ();

  inst_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .imem       (imem_bus.master),
    .Inst       (Inst),
    .inst_valid (inst_valid),
    .PC         (PC),
    .ex_done    (ex_done),
    .Jump       (Jump),
    .Branch     (Branch),
    .Zero       (Zero),
    .retired    (retired)
  );

  inst_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk        (clk),
    .rst        (rst_w),
    .imem       (imem_bus_w.master),
    .Inst       (inst_w),
    .inst_valid (inst_valid_w),
    .PC         (pc_w),
    .ex_done    (ex_done),
    .Jump       (Jump),
    .Branch     (Branch),
    .Zero       (Zero),
    .retired    (retired_w)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_retired;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        jump;
    logic        branch;
    logic        zero;
    int          ack_lat;   // cycles of request before ack
    logic [31:0] next_pc;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a request, then compare its address with the scoreboard.
  task automatic wait_req(input string name);
    logic [31:0] exp;
    for (int i = 0; i < 20 && !imem_bus.imem_req; i++) tick();
    check({name, "_req"}, {31'd0, imem_bus.imem_req}, 32'd1);
    if (exp_addr_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_sb: request seen, scoreboard empty", name);
    end else begin
      exp = exp_addr_q.pop_front();
      check({name, "_addr"}, imem_bus.imem_addr, exp);
    end
  endtask

  initial begin
    // pc, inst, J, B, Z, ack latency, expected next PC
    vecs[0]  = '{32'h0000_3000, 32'h2000_0000, 1'b0, 1'b0, 1'b0, 1, 32'h0000_3004};
    vecs[1]  = '{32'h0000_3004, 32'h2000_0001, 1'b0, 1'b0, 1'b0, 1, 32'h0000_3008};
    vecs[2]  = '{32'h0000_3008, 32'h1000_0001, 1'b0, 1'b1, 1'b1, 1, 32'h0000_3010};
    vecs[3]  = '{32'h0000_3010, 32'h1000_FFFF, 1'b0, 1'b1, 1'b1, 0, 32'h0000_3010};
    vecs[4]  = '{32'h0000_3010, 32'h1000_FFFF, 1'b0, 1'b1, 1'b0, 2, 32'h0000_3014};
    vecs[5]  = '{32'h0000_3014, 32'h0800_0C00, 1'b1, 1'b0, 1'b0, 0, 32'h0000_3000};
    vecs[6]  = '{32'h0000_3000, 32'h0800_0C40, 1'b1, 1'b1, 1'b1, 1, 32'h0000_3100};
    vecs[7]  = '{32'h0000_3100, 32'h1000_8000, 1'b0, 1'b1, 1'b1, 0, 32'hFFFE_3104};
    vecs[8]  = '{32'hFFFE_3104, 32'h0BFF_FFFF, 1'b1, 1'b0, 1'b0, 1, 32'hFFFF_FFFC};
    vecs[9]  = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 0, 32'h0000_0000};
    vecs[10] = '{32'h0000_0000, 32'h1000_0004, 1'b0, 1'b1, 1'b0, 1, 32'h0000_0004};

    rst      = 1'b1;
    rst_w    = 1'b1;
    ex_done  = 1'b0;
    Jump     = 1'b0;
    Branch   = 1'b0;
    Zero     = 1'b0;
    imem_bus.imem_ack     = 1'b0;
    imem_bus.imem_rdata   = 32'd0;
    imem_bus_w.imem_ack   = 1'b0;
    imem_bus_w.imem_rdata = 32'd0;

    // ---------------- reset state ----------------
    tick();
    tick();
    check("rst_req",     {31'd0, imem_bus.imem_req}, 32'd0);
    check("rst_valid",   {31'd0, inst_valid},        32'd0);
    check("rst_pc",      PC,                         32'h0000_3000);
    check("rst_inst",    Inst,                       32'd0);
    check("rst_retired", retired,                    32'd0);

    rst = 1'b0;
    exp_retired = 32'd0;
    exp_addr_q.push_back(32'h0000_3000);
    check("idle_no_req", {31'd0, imem_bus.imem_req}, 32'd0);
    tick();
    check("first_req", {31'd0, imem_bus.imem_req}, 32'd1);

    // ---------------- table-driven instruction stream ----------------
    foreach (vecs[i]) begin
      wait_req($sformatf("v%0d", i));
      check($sformatf("v%0d_pc", i), PC, vecs[i].pc);
      for (int w = 0; w < vecs[i].ack_lat; w++) begin
        tick();
        check($sformatf("v%0d_req_hold", i), {31'd0, imem_bus.imem_req}, 32'd1);
      end
      imem_bus.imem_ack   = 1'b1;
      imem_bus.imem_rdata = vecs[i].inst;
      tick();
      imem_bus.imem_ack   = 1'b0;
      imem_bus.imem_rdata = 32'hBAD0_BAD0;
      check($sformatf("v%0d_valid", i), {31'd0, inst_valid}, 32'd1);
      check($sformatf("v%0d_inst", i), Inst, vecs[i].inst);
      check($sformatf("v%0d_req_low", i), {31'd0, imem_bus.imem_req}, 32'd0);

      ex_done = 1'b1;
      Jump    = vecs[i].jump;
      Branch  = vecs[i].branch;
      Zero    = vecs[i].zero;
      exp_addr_q.push_back(vecs[i].next_pc);
      exp_retired = exp_retired + 32'd1;
      tick();
      ex_done = 1'b0;
      Jump    = 1'b0;
      Branch  = 1'b0;
      Zero    = 1'b0;
      check($sformatf("v%0d_retired", i), retired, exp_retired);
      check($sformatf("v%0d_pc_lo", i), {30'd0, PC[1:0]}, 32'd0);
      check($sformatf("v%0d_valid_low", i), {31'd0, inst_valid}, 32'd0);
    end

    // ---------------- ack held during ISSUE is ignored ----------------
    wait_req("hold");
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = 32'h2000_0055;
    tick();
    imem_bus.imem_rdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold_inst",  Inst, 32'h2000_0055);
      check("hold_valid", {31'd0, inst_valid}, 32'd1);
    end
    imem_bus.imem_ack = 1'b0;
    ex_done = 1'b1;
    exp_addr_q.push_back(32'h0000_0008);
    exp_retired = exp_retired + 32'd1;
    tick();
    ex_done = 1'b0;
    check("hold_retired", retired, exp_retired);

    // ---------------- ex_done in REQ is ignored ----------------
    wait_req("exreq");
    ex_done = 1'b1;
    Jump    = 1'b1;
    tick();
    ex_done = 1'b0;
    Jump    = 1'b0;
    check("exreq_pc",      PC,      32'h0000_0008);
    check("exreq_retired", retired, exp_retired);
    check("exreq_req",     {31'd0, imem_bus.imem_req}, 32'd1);

    // ---------------- reset in ISSUE with ex_done ----------------
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = 32'h0800_0001;
    tick();
    imem_bus.imem_ack = 1'b0;
    check("mid_valid_pre", {31'd0, inst_valid}, 32'd1);
    rst     = 1'b1;
    ex_done = 1'b1;
    Jump    = 1'b1;
    tick();
    ex_done = 1'b0;
    Jump    = 1'b0;
    check("mid_pc",      PC,      32'h0000_3000);
    check("mid_retired", retired, 32'd0);
    check("mid_valid",   {31'd0, inst_valid}, 32'd0);
    check("mid_inst",    Inst,    32'd0);
    rst = 1'b0;
    // Late ack from the abandoned fetch arrives while IDLE.
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = 32'h1234_5678;
    tick();
    imem_bus.imem_ack = 1'b0;
    check("late_ack_inst", Inst, 32'd0);
    check("late_ack_req",  {31'd0, imem_bus.imem_req}, 32'd1);
    check("late_ack_addr", imem_bus.imem_addr, 32'h0000_3000);

    // ---------------- reset overrides ack in REQ ----------------
    rst = 1'b1;
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = 32'h5555_AAAA;
    tick();
    imem_bus.imem_ack = 1'b0;
    check("rst_ack_inst",  Inst, 32'd0);
    check("rst_ack_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_ack_req",   {31'd0, imem_bus.imem_req}, 32'd0);

    // ---------------- PC wrap on the second instance ----------------
    rst_w = 1'b0;
    tick();
    check("wrap_req",  {31'd0, imem_bus_w.imem_req}, 32'd1);
    check("wrap_addr", imem_bus_w.imem_addr, 32'hFFFF_FFFC);
    imem_bus_w.imem_ack   = 1'b1;
    imem_bus_w.imem_rdata = 32'h2000_0000;
    tick();
    imem_bus_w.imem_ack = 1'b0;
    check("wrap_valid", {31'd0, inst_valid_w}, 32'd1);
    ex_done = 1'b1;
    tick();
    ex_done = 1'b0;
    check("wrap_next_req",  {31'd0, imem_bus_w.imem_req}, 32'd1);
    check("wrap_next_addr", imem_bus_w.imem_addr, 32'h0000_0000);
    check("wrap_retired",   retired_w, 32'd1);
    check("wrap_inst",      inst_w,    32'h2000_0000);
    check("wrap_pc",        pc_w,      32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
